// File: rtl/adder_stim_sequencer.sv
// Stimulus driver and result checker for the lab4 adder: plays the LoadB/Run
// button sequence, waits for the adder to settle, then checks {CO,Sum} against A+B.
module adder_stim_sequencer #(
   parameter int WIDTH    = 16,
   parameter int LOAD_CYC = 1,
   parameter int RUN_CYC  = 1,
   parameter int WAIT_CYC = 32,
   parameter int ERR_W    = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic [WIDTH-1:0] SW,
   output logic             LoadB,
   output logic             Run,
   input  logic [WIDTH-1:0] Sum,
   input  logic             CO,
   output logic             Busy,
   output logic             Done,
   output logic             Pass,
   output logic [ERR_W-1:0] ErrCount
);

   localparam int MAX_LR  = (LOAD_CYC > RUN_CYC) ? LOAD_CYC : RUN_CYC;
   localparam int MAX_CYC = (MAX_LR > WAIT_CYC) ? MAX_LR : WAIT_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYC - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_B,
      S_SET_A,
      S_RUN,
      S_WAIT,
      S_CHECK
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sw_q, sw_d;
   logic             loadb_q, loadb_d;
   logic             run_q, run_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_q, err_d;

   logic [WIDTH:0]   expect_sum;
   logic             match;

   // Full-width sum so the carry is compared against CO as well.
   assign expect_sum = {1'b0, a_q} + {1'b0, b_q};
   assign match      = ({CO, Sum} == expect_sum);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;

      case (state_q)
         S_IDLE: begin
            if (Start) begin
               a_d     = OpA;
               b_d     = OpB;
               cnt_d   = '0;
               state_d = S_LOAD_B;
            end
         end
         S_LOAD_B: begin
            if (cnt_q == LOAD_LAST) begin
               cnt_d   = '0;
               state_d = S_SET_A;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SET_A: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == RUN_LAST) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            pass_d  = match;
            if (!match && (err_q != ERR_MAX)) begin
               err_d = err_q + ERR_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Registered outputs are decoded from the next state so they change on
      // the same edge as the state itself.
      sw_d    = sw_q;
      loadb_d = 1'b1;
      run_d   = 1'b1;
      busy_d  = 1'b1;
      case (state_d)
         S_IDLE:   busy_d = 1'b0;
         S_LOAD_B: begin
            sw_d    = b_d;
            loadb_d = 1'b0;
         end
         S_SET_A,
         S_WAIT,
         S_CHECK:  sw_d = a_d;
         S_RUN: begin
            sw_d  = a_d;
            run_d = 1'b0;
         end
         default:  busy_d = 1'b0;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sw_q    <= '0;
         loadb_q <= 1'b1;
         run_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sw_q    <= sw_d;
         loadb_q <= loadb_d;
         run_q   <= run_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
      end
   end

   assign SW       = sw_q;
   assign LoadB    = loadb_q;
   assign Run      = run_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Pass     = pass_q;
   assign ErrCount = err_q;

endmodule

// File: tb/tb_adder_stim_sequencer.sv
// Directed bench for adder_stim_sequencer with a behavioural lab4 adder
// (B register loaded on LoadB low, sum registered on Run low, optional stuck-at-0 sum).
module tb_adder_stim_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Start;
   logic [15:0] OpA, OpB;
   logic [15:0] SW;
   logic        LoadB, Run;
   logic [15:0] Sum;
   logic        CO;
   logic        Busy, Done, Pass;
   logic [7:0]  ErrCount;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] b_reg;
   logic [15:0] sum_m;
   logic        co_m;
   logic        stuck;

   adder_stim_sequencer dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .OpA(OpA), .OpB(OpB),
      .SW(SW), .LoadB(LoadB), .Run(Run), .Sum(Sum), .CO(CO),
      .Busy(Busy), .Done(Done), .Pass(Pass), .ErrCount(ErrCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         b_reg <= '0;
         sum_m <= '0;
         co_m  <= 1'b0;
      end else begin
         if (!LoadB) b_reg <= SW;
         if (!Run) {co_m, sum_m} <= stuck ? 17'h0 : ({1'b0, SW} + {1'b0, b_reg});
      end
   end
   assign Sum = sum_m;
   assign CO  = co_m;

   // One transaction with a one-cycle Start; returns the edge index of Done (-1 on timeout).
   task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                          output int done_edge, output logic pass_seen);
      done_edge = -1;
      pass_seen = 1'bx;
      @(negedge Clk);
      OpA = a; OpB = b; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge Clk);
         if (Done) begin
            done_edge = k;
            pass_seen = Pass;
            break;
         end
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; Start = 1'b0; OpA = '0; OpB = '0; stuck = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      n_checks++; if (SW !== 16'h0) begin n_fail++; $display("FAIL reset_sw got %h want 0000", SW); end
      n_checks++; if ({LoadB, Run} !== 2'b11) begin n_fail++; $display("FAIL reset_ctl got %b want 11", {LoadB, Run}); end
      n_checks++; if ({Busy, Done, Pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {Busy, Done, Pass}); end
      n_checks++; if (ErrCount !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", ErrCount); end
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_basic_add();
      int done_edge = -1;
      @(negedge Clk);
      OpA = 16'h0004; OpB = 16'h0008; Start = 1'b1;
      @(negedge Clk);  // after edge 0
      Start = 1'b0;
      n_checks++; if ({Busy, LoadB, SW} !== {1'b1, 1'b0, 16'h0008}) begin n_fail++; $display("FAIL basic_loadb got busy=%b lb=%b sw=%h want 1 0 0008", Busy, LoadB, SW); end
      @(negedge Clk);  // edge 1: SET_A
      n_checks++; if ({LoadB, Run, SW} !== {1'b1, 1'b1, 16'h0004}) begin n_fail++; $display("FAIL basic_seta got lb=%b run=%b sw=%h want 1 1 0004", LoadB, Run, SW); end
      @(negedge Clk);  // edge 2: RUN
      n_checks++; if ({Run, SW} !== {1'b0, 16'h0004}) begin n_fail++; $display("FAIL basic_run got run=%b sw=%h want 0 0004", Run, SW); end
      @(negedge Clk);  // edge 3: WAIT
      n_checks++; if (Run !== 1'b1) begin n_fail++; $display("FAIL basic_run_rel got %b want 1", Run); end
      for (int k = 4; k <= 100; k++) begin
         @(negedge Clk);
         if (Done) begin done_edge = k; break; end
      end
      n_checks++; if (done_edge !== 36) begin n_fail++; $display("FAIL basic_latency got %0d want 36", done_edge); end
      n_checks++; if ({Pass, ErrCount} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL basic_result got pass=%b err=%0d want 1 0", Pass, ErrCount); end
      @(negedge Clk);
      n_checks++; if ({Done, Busy} !== 2'b00) begin n_fail++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", Done, Busy); end
   endtask

   task automatic test_carry();
      int   e;
      logic p;
      run_txn(16'hFFFF, 16'h0001, e, p);
      n_checks++; if (e !== 36) begin n_fail++; $display("FAIL carry_latency got %0d want 36", e); end
      n_checks++; if ({p, ErrCount} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL carry_result got pass=%b err=%0d want 1 0", p, ErrCount); end
   endtask

   task automatic test_error();
      int   e;
      logic p;
      stuck = 1'b1;
      run_txn(16'h1234, 16'h1111, e, p);
      n_checks++; if ({p, ErrCount} !== {1'b0, 8'd1}) begin n_fail++; $display("FAIL err_first got pass=%b err=%0d want 0 1", p, ErrCount); end
      for (int i = 2; i <= 255; i++) run_txn(16'h1234, 16'h1111, e, p);
      n_checks++; if (ErrCount !== 8'd255) begin n_fail++; $display("FAIL err_255 got %0d want 255", ErrCount); end
      for (int i = 256; i <= 300; i++) run_txn(16'h1234, 16'h1111, e, p);
      n_checks++; if ({p, ErrCount} !== {1'b0, 8'd255}) begin n_fail++; $display("FAIL err_saturate got pass=%b err=%0d want 0 255", p, ErrCount); end
      stuck = 1'b0;
      run_txn(16'h1234, 16'h1111, e, p);
      n_checks++; if ({p, ErrCount} !== {1'b1, 8'd255}) begin n_fail++; $display("FAIL err_recover got pass=%b err=%0d want 1 255", p, ErrCount); end
      repeat (5) @(negedge Clk);
      n_checks++; if (Pass !== 1'b1) begin n_fail++; $display("FAIL pass_hold got %b want 1", Pass); end
   endtask

   task automatic test_busy_ignore();
      int n_done     = 0;
      int first_done = -1;
      @(negedge Clk);
      OpA = 16'h0100; OpB = 16'h0200; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge Clk);
         if (k == 10) begin OpA = 16'h7777; OpB = 16'h5555; Start = 1'b1; end
         if (k == 11) begin
            Start = 1'b0;
            n_checks++; if ({Busy, SW} !== {1'b1, 16'h0100}) begin n_fail++; $display("FAIL busy_sw got busy=%b sw=%h want 1 0100", Busy, SW); end
         end
         if (Done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
      end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL busy_done_count got %0d want 1", n_done); end
      n_checks++; if (first_done !== 36) begin n_fail++; $display("FAIL busy_latency got %0d want 36", first_done); end
      n_checks++; if ({Pass, SW} !== {1'b1, 16'h0100}) begin n_fail++; $display("FAIL busy_result got pass=%b sw=%h want 1 0100", Pass, SW); end
   endtask

   task automatic test_back_to_back();
      int d1 = -1;
      int d2 = -1;
      @(negedge Clk);
      OpA = 16'h0003; OpB = 16'h0005; Start = 1'b1;
      @(negedge Clk);
      for (int k = 1; k <= 100; k++) begin
         @(negedge Clk);
         if (Done) begin d1 = k; break; end
      end
      n_checks++; if ({d1 == 36, Busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_first got edge=%0d busy=%b want 36 0", d1, Busy); end
      @(negedge Clk);
      Start = 1'b0;
      n_checks++; if ({Busy, LoadB, SW} !== {1'b1, 1'b0, 16'h0005}) begin n_fail++; $display("FAIL b2b_restart got busy=%b lb=%b sw=%h want 1 0 0005", Busy, LoadB, SW); end
      for (int k = d1 + 2; k <= d1 + 100; k++) begin
         @(negedge Clk);
         if (Done) begin d2 = k; break; end
      end
      n_checks++; if (d2 !== 73) begin n_fail++; $display("FAIL b2b_second got edge=%0d want 73", d2); end
      n_checks++; if (Pass !== 1'b1) begin n_fail++; $display("FAIL b2b_pass got %b want 1", Pass); end
   endtask

   task automatic test_reset_mid();
      bit   in_run = 1'b0;
      int   n_done = 0;
      int   e;
      logic p;
      @(negedge Clk);
      OpA = 16'h0004; OpB = 16'h0008; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         if (!Run) begin in_run = 1'b1; break; end
      end
      n_checks++; if (in_run !== 1'b1) begin n_fail++; $display("FAIL mid_reach_run got %b want 1", in_run); end
      #2 Reset = 1'b0;
      #1;
      n_checks++; if ({Run, LoadB, Busy, Done} !== 4'b1100) begin n_fail++; $display("FAIL mid_async_ctl got %b want 1100", {Run, LoadB, Busy, Done}); end
      n_checks++; if ({SW, ErrCount} !== {16'h0, 8'd0}) begin n_fail++; $display("FAIL mid_async_data got sw=%h err=%0d want 0000 0", SW, ErrCount); end
      @(negedge Clk);
      Reset = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clk);
         if (Done) n_done++;
      end
      n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d want 0", n_done); end
      run_txn(16'h0004, 16'h0008, e, p);
      n_checks++; if ({e == 36, p, ErrCount} !== {1'b1, 1'b1, 8'd0}) begin n_fail++; $display("FAIL mid_after got edge=%0d pass=%b err=%0d want 36 1 0", e, p, ErrCount); end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry();
      test_error();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adder_stim_sequencer.md
Name: adder_stim_sequencer

Overview:
- On-chip stimulus driver and result checker for the lab4 adder top-level. It replaces manual push-button/switch operation.
- Drives the adder's SW, LoadB and Run inputs with the button-style load/run sequence.
- Waits a fixed settling time, then samples Sum/CO and compares them against an internally computed A+B.
- Sits beside the adder top-level and reports pass/fail plus a running error count to LEDs/hex.

Parameters:
- WIDTH, 16, operand/sum width; must match the adder's SW/Sum width.
- LOAD_CYC, 1, cycles LoadB is held low (min 1).
- RUN_CYC, 1, cycles Run is held low (min 1).
- WAIT_CYC, 32, cycles waited after Run release before sampling Sum/CO (min 1); sized for the slowest adder variant.
- ERR_W, 8, width of the saturating error counter.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request one add/check transaction; level-sampled.
- OpA  input  WIDTH  operand A (loaded through SW at Run time).
- OpB  input  WIDTH  operand B (loaded through SW with LoadB).
- SW  output  WIDTH  drives the adder's SW input.
- LoadB  output  1  drives the adder's LoadB, active-low.
- Run  output  1  drives the adder's Run, active-low.
- Sum  input  WIDTH  from the adder.
- CO  input  1  from the adder.
- Busy  output  1  transaction in progress.
- Done  output  1  one-cycle pulse when the check completes.
- Pass  output  1  result of the last completed check.
- ErrCount  output  ERR_W  number of failed checks, saturating.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State=IDLE, SW=0, LoadB=1, Run=1, Busy=0, Done=0, Pass=0, ErrCount=0.
  - Latched operands and the internal counter are cleared.
- All outputs are registered.
- FSM states: IDLE, LOAD_B, SET_A, RUN, WAIT, CHECK.
- IDLE:
  - LoadB=1, Run=1, SW holds its last value.
  - If Start=1 at a clock edge, OpA/OpB are latched, the state goes to LOAD_B and Busy=1 from that edge.
- LOAD_B: SW=latched B, LoadB=0, for LOAD_CYC cycles, then SET_A.
- SET_A: SW=latched A, LoadB=1, for 1 cycle, then RUN.
- RUN: SW=latched A, Run=0, for RUN_CYC cycles, then WAIT.
- WAIT: Run=1, SW=latched A, for WAIT_CYC cycles, then CHECK.
- CHECK:
  - Samples {CO,Sum} and compares against the (WIDTH+1)-bit sum A+B, zero-extended.
  - Next edge: state=IDLE, Busy=0, Done=1 for exactly one cycle, Pass=(match).
  - On mismatch, ErrCount increments; it holds at 2^ERR_W-1 (no wrap).
- Latency: Start accepted at edge 0 gives Done high after edge N = LOAD_CYC+1+RUN_CYC+WAIT_CYC+1. With defaults, N=36.
- Pass holds until the next Done. ErrCount is only cleared by reset.
- Start while Busy=1 is ignored; the operands are not re-latched.
- Start=1 during the Done cycle, or held continuously, is accepted at that edge: back-to-back transactions, with Busy low for exactly one cycle between them.
- OpA/OpB changes after acceptance have no effect on the current transaction.
- Reset asserted mid-transaction:
  - Outputs return immediately, without waiting for the clock, to reset values; LoadB/Run release (=1).
  - No Done is produced and ErrCount is cleared.
- Arithmetic: the expected value is the full WIDTH+1-bit sum, with the carry compared against CO. No signed interpretation.

Test Plan:
- Basic add: Reset low then high, Start 1 cycle with OpA=0x0004, OpB=0x0008.
  - SW=0x0008 with LoadB=0 for 1 cycle, then SW=0x0004.
  - Run=0 for 1 cycle.
  - Done at edge 36 with Pass=1, ErrCount=0.
  - A correct adder model shows Sum=0x000C, CO=0.
- Carry out: OpA=0xFFFF, OpB=0x0001 with a correct adder → Sum=0x0000, CO=1, Pass=1.
- Error path: adder model with Sum stuck at 0x0000, OpA=0x1234, OpB=0x1111.
  - Pass=0, ErrCount=1.
  - Repeat 300 times with ERR_W=8 → ErrCount saturates at 255.
- Busy/back-to-back:
  - Pulse Start again at cycle 10 of a transaction → ignored; SW still shows the first operands; exactly one Done.
  - Hold Start high → second transaction begins at the Done edge; Busy low for exactly 1 cycle.
- Reset mid-operation: assert Reset between clock edges while in RUN (Run=0).
  - Run=1, LoadB=1, SW=0, Busy=0, ErrCount=0 without waiting for a clock edge.
  - No Done pulse; the next Start behaves as in the basic-add scenario.
